lane_compactor_w10: RTL and testbench

- Upstream feeder for the 10-write/1-read multi-entry FIFO.
- Accepts up to 10 sparse input lanes per cycle, each qualified by its own valid bit. Compacts the valid lanes into a contiguous low-aligned word vector plus a count, which drive the FIFO's writes/din inputs.
- Holds the presented group until the FIFO's combinational taken is high.
- A two-entry output register plus skid register gives full throughput with a registered in_ready.

---
 rtl/lane_compactor_w10.sv | 138 +++++++++++++
 tb/tb_lane_compactor_w10.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_compactor_w10.sv
// Compacts up to 10 sparse valid lanes into a low-aligned word vector plus count,
// buffered by an output register and a skid register. Optional stats: LANE_COMPACT_STATS_EN.
module lane_compactor_w10 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  softreset,
  input  logic [9:0]            in_valid,
  input  logic [WIDTH*10-1:0]   in_data,
  output logic                  in_ready,
  output logic [3:0]            writes,
  output logic [WIDTH*10-1:0]   din,
  input  logic                  taken
`ifdef LANE_COMPACT_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [31:0]           stat_stalls
`endif
);

  localparam int unsigned LANES  = 10;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = WIDTH * LANES;

  logic [CNT_W-1:0]  cmp_cnt;
  logic [DATA_W-1:0] cmp_data;

  logic              skd_valid;
  logic [CNT_W-1:0]  skd_cnt;
  logic [DATA_W-1:0] skd_data;

  logic              skd_valid_nxt;
  logic [CNT_W-1:0]  skd_cnt_nxt;
  logic [DATA_W-1:0] skd_data_nxt;
  logic [CNT_W-1:0]  writes_nxt;
  logic [DATA_W-1:0] din_nxt;
  logic              in_ready_nxt;

  logic acc;
  logic xfer;
  logic out_free;

  assign acc      = in_ready && (in_valid != '0);
  assign xfer     = (writes != '0) && taken;
  assign out_free = (writes == '0) || xfer;

  // Scan lanes upward; each valid lane lands in the next free low slice.
  always_comb begin
    cmp_cnt  = '0;
    cmp_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (in_valid[i]) begin
        cmp_data[32'(cmp_cnt) * WIDTH +: WIDTH] = in_data[i * WIDTH +: WIDTH];
        cmp_cnt = cmp_cnt + CNT_W'(1);
      end
    end
  end

  // Output/skid next state; softreset overrides any transfer.
  always_comb begin
    writes_nxt    = writes;
    din_nxt       = din;
    skd_valid_nxt = skd_valid;
    skd_cnt_nxt   = skd_cnt;
    skd_data_nxt  = skd_data;
    if (softreset) begin
      writes_nxt    = '0;
      din_nxt       = '0;
      skd_valid_nxt = 1'b0;
      skd_cnt_nxt   = '0;
      skd_data_nxt  = '0;
    end else if (out_free) begin
      if (skd_valid) begin
        writes_nxt = skd_cnt;
        din_nxt    = skd_data;
        if (acc) begin
          skd_cnt_nxt  = cmp_cnt;
          skd_data_nxt = cmp_data;
        end else begin
          skd_valid_nxt = 1'b0;
          skd_cnt_nxt   = '0;
          skd_data_nxt  = '0;
        end
      end else if (acc) begin
        writes_nxt = cmp_cnt;
        din_nxt    = cmp_data;
      end else begin
        writes_nxt = '0;
        din_nxt    = '0;
      end
    end else if (acc) begin
      skd_valid_nxt = 1'b1;
      skd_cnt_nxt   = cmp_cnt;
      skd_data_nxt  = cmp_data;
    end
    in_ready_nxt = !skd_valid_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writes    <= '0;
      din       <= '0;
      skd_valid <= 1'b0;
      skd_cnt   <= '0;
      skd_data  <= '0;
      in_ready  <= 1'b1;
    end else begin
      writes    <= writes_nxt;
      din       <= din_nxt;
      skd_valid <= skd_valid_nxt;
      skd_cnt   <= skd_cnt_nxt;
      skd_data  <= skd_data_nxt;
      in_ready  <= in_ready_nxt;
    end
  end

`ifdef LANE_COMPACT_STATS_EN
  // Word count wraps; stall count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else if (softreset) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      if (xfer) begin
        stat_words <= stat_words + 32'(writes);
      end
      if ((writes != '0) && !taken && (stat_stalls != '1)) begin
        stat_stalls <= stat_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lane_compactor_w10.sv
// Self-checking bench for lane_compactor_w10: randomized groups checked against a
// queue-based model of the in-flight groups (at most two outstanding).
module tb_lane_compactor_w10;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned LANES  = 10;
  localparam int unsigned DATA_W = WIDTH * LANES;

  logic              clk;
  logic              rst_n;
  logic              softreset;
  logic [9:0]        in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [3:0]        writes;
  logic [DATA_W-1:0] din;
  logic              taken;
`ifdef LANE_COMPACT_STATS_EN
  logic [31:0]       stat_words;
  logic [31:0]       stat_stalls;
`endif

  lane_compactor_w10 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .softreset (softreset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .writes    (writes),
    .din       (din),
    .taken     (taken)
`ifdef LANE_COMPACT_STATS_EN
    ,
    .stat_words  (stat_words),
    .stat_stalls (stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: groups accepted but not yet taken, oldest first.
  int unsigned       q_cnt[$];
  logic [DATA_W-1:0] q_data[$];
  int unsigned       n_xfer = 0;
  bit                last_acc = 1'b0;
  logic [31:0]       m_words = '0;
  logic [31:0]       m_stalls = '0;
  logic [3:0]        exp_writes;
  logic [DATA_W-1:0] exp_din;
  logic              exp_ready;

  function automatic logic [DATA_W-1:0] ref_compact(input logic [9:0] v, input logic [DATA_W-1:0] d);
    logic [WIDTH-1:0]  words[$];
    logic [DATA_W-1:0] r;
    for (int i = 0; i < int'(LANES); i++)
      if (v[i]) words.push_back(d[i*WIDTH +: WIDTH]);
    r = '0;
    foreach (words[k]) r[k*WIDTH +: WIDTH] = words[k];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < int'(LANES); i++) r[i*WIDTH +: WIDTH] = $urandom();
    return r;
  endfunction

  task automatic update_exp();
    exp_writes = (q_cnt.size() == 0) ? 4'd0 : 4'(q_cnt[0]);
    exp_din    = (q_data.size() == 0) ? '0 : q_data[0];
    exp_ready  = (q_cnt.size() < 2);
  endtask

  // Drive one cycle of inputs, advance the model across the edge.
  task automatic drive_cycle(input logic [9:0] v, input logic [DATA_W-1:0] d, input logic t, input logic sr);
    bit acc;
    bit xfer;
    in_valid  = v;
    in_data   = d;
    taken     = t;
    softreset = sr;
    acc  = (q_cnt.size() < 2) && (v != '0);
    xfer = (q_cnt.size() != 0) && t;
    @(posedge clk);
    #1;
    if (sr) begin
      q_cnt.delete();
      q_data.delete();
      m_words  = '0;
      m_stalls = '0;
      last_acc = 1'b0;
    end else begin
      if (q_cnt.size() != 0 && !t && m_stalls != '1) m_stalls = m_stalls + 32'd1;
      if (xfer) begin
        m_words = m_words + 32'(q_cnt[0]);
        void'(q_cnt.pop_front());
        void'(q_data.pop_front());
        n_xfer++;
      end
      if (acc) begin
        q_cnt.push_back(32'($countones(v)));
        q_data.push_back(ref_compact(v, d));
      end
      last_acc = acc;
    end
    update_exp();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; softreset = 1'b0; taken = 1'b1;
    in_valid = 10'h3FF; in_data = rand_data();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (writes !== 4'd0) begin errors++; $display("FAIL reset_writes: got %0d want 0", writes); end
    checks++; if (din !== '0) begin errors++; $display("FAIL reset_din: got %h want 0", din); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    in_valid = '0; taken = 1'b0;
    rst_n = 1'b1;
    q_cnt.delete(); q_data.delete();
    update_exp();
  endtask

  task automatic test_sparse();
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] want;
    d = rand_data();
    d[0*WIDTH +: WIDTH] = 32'hA0; d[2*WIDTH +: WIDTH] = 32'hA2;
    d[5*WIDTH +: WIDTH] = 32'hA5; d[9*WIDTH +: WIDTH] = 32'hA9;
    want = '0;
    want[0*WIDTH +: WIDTH] = 32'hA0; want[1*WIDTH +: WIDTH] = 32'hA2;
    want[2*WIDTH +: WIDTH] = 32'hA5; want[3*WIDTH +: WIDTH] = 32'hA9;
    drive_cycle(10'b10_0010_0101, d, 1'b1, 1'b0);
    checks++; if (writes !== 4'd4) begin errors++; $display("FAIL sparse_writes: got %0d want 4", writes); end
    checks++; if (din !== want) begin errors++; $display("FAIL sparse_din: got %h want %h", din, want); end
    drive_cycle('0, rand_data(), 1'b1, 1'b0);
    checks++; if (writes !== 4'd0) begin errors++; $display("FAIL sparse_drain: got %0d want 0", writes); end
  endtask

  task automatic test_extremes();
    logic [9:0]        masks[3];
    logic [DATA_W-1:0] d;
    masks[0] = 10'h3FF; masks[1] = 10'h200; masks[2] = 10'h000;
    for (int m = 0; m < 3; m++) begin
      d = rand_data();
      drive_cycle(masks[m], d, 1'b1, 1'b0);
      checks++; if (writes !== 4'($countones(masks[m]))) begin errors++; $display("FAIL extreme_writes mask=%h: got %0d want %0d", masks[m], writes, $countones(masks[m])); end
      checks++; if (din !== exp_din) begin errors++; $display("FAIL extreme_din mask=%h: got %h want %h", masks[m], din, exp_din); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL extreme_ready mask=%h: got %b want 1", masks[m], in_ready); end
      if (m == 1) begin
        checks++; if (din[WIDTH-1:0] !== d[9*WIDTH +: WIDTH]) begin errors++; $display("FAIL extreme_lane9: got %h want %h", din[WIDTH-1:0], d[9*WIDTH +: WIDTH]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] d3;
    logic [3:0]        seq[3];
    int                budget;
    seq[0] = 4'd3; seq[1] = 4'd2; seq[2] = 4'd5;
    drive_cycle('0, '0, 1'b1, 1'b0);
    drive_cycle(10'b00_0001_0011, rand_data(), 1'b0, 1'b0);
    checks++; if (writes !== 4'd3) begin errors++; $display("FAIL bp_g1_writes: got %0d want 3", writes); end
    drive_cycle(10'b10_0000_0001, rand_data(), 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_g2: got %b want 0", in_ready); end
    d3 = rand_data();
    drive_cycle(10'b01_0101_0101, d3, 1'b0, 1'b0);
    checks++; if (last_acc || writes !== 4'd3 || din !== exp_din) begin errors++; $display("FAIL bp_hold: writes=%0d want 3, acc=%0d want 0", writes, last_acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_g3_stalled: got %b want 0", in_ready); end
    // Raise taken; G3 offered until accepted, then idle.
    budget = 0;
    for (int k = 0; k < 3; k++) begin
      if (writes !== seq[k] || din !== exp_din) begin
        errors++; $display("FAIL bp_order k=%0d: writes=%0d want %0d", k, writes, seq[k]);
      end
      checks++;
      if (k < 2 && budget == 0 && !last_acc) drive_cycle(10'b01_0101_0101, d3, 1'b1, 1'b0);
      else drive_cycle('0, '0, 1'b1, 1'b0);
      if (last_acc) budget = 1;
    end
    checks++; if (writes !== 4'd0 || budget != 1) begin errors++; $display("FAIL bp_drain: writes=%0d want 0, g3_accepted=%0d want 1", writes, budget); end
  endtask

  task automatic test_streaming();
    int unsigned start_xfer;
    int          bad = 0;
    drive_cycle('0, '0, 1'b1, 1'b0);
    start_xfer = n_xfer;
    for (int g = 0; g < 20; g++) begin
      drive_cycle(10'($urandom_range(1, 1023)), rand_data(), 1'b1, 1'b0);
      if (in_ready !== 1'b1 || writes !== exp_writes || din !== exp_din) begin
        bad++; $display("FAIL stream g=%0d: ready=%b writes=%0d want ready=1 writes=%0d", g, in_ready, writes, exp_writes);
      end
    end
    drive_cycle('0, '0, 1'b1, 1'b0);
    checks++; if (bad != 0) errors++;
    checks++; if (n_xfer - start_xfer != 20 || writes !== 4'd0) begin errors++; $display("FAIL stream_count: transfers=%0d want 20, writes=%0d want 0", n_xfer - start_xfer, writes); end
  endtask

  task automatic test_softreset();
    drive_cycle(10'h0F0, rand_data(), 1'b0, 1'b0);
    drive_cycle(10'h00F, rand_data(), 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0 || writes !== 4'd4) begin errors++; $display("FAIL sr_full: ready=%b writes=%0d want 0 and 4", in_ready, writes); end
    drive_cycle(10'h3FF, rand_data(), 1'b0, 1'b1);
    checks++; if (writes !== 4'd0) begin errors++; $display("FAIL sr_writes: got %0d want 0", writes); end
    checks++; if (din !== '0) begin errors++; $display("FAIL sr_din: got %h want 0", din); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sr_ready: got %b want 1", in_ready); end
    for (int c = 0; c < 3; c++) begin
      drive_cycle('0, '0, 1'b1, 1'b0);
      checks++; if (writes !== 4'd0) begin errors++; $display("FAIL sr_ghost c=%0d: writes=%0d want 0", c, writes); end
    end
  endtask

  task automatic test_random();
    logic [9:0] v;
    for (int c = 0; c < 300; c++) begin
      v = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      drive_cycle(v, rand_data(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
      checks++;
      if (writes !== exp_writes || din !== exp_din || in_ready !== exp_ready) begin
        errors++;
        $display("FAIL random c=%0d: writes=%0d ready=%b want writes=%0d ready=%b", c, writes, in_ready, exp_writes, exp_ready);
      end
    end
  endtask

`ifdef LANE_COMPACT_STATS_EN
  task automatic test_stats();
    drive_cycle('0, '0, 1'b0, 1'b1);
    drive_cycle(10'h00F, rand_data(), 1'b0, 1'b0);
    repeat (5) drive_cycle('0, '0, 1'b0, 1'b0);
    drive_cycle(10'h3FF, rand_data(), 1'b1, 1'b0);
    drive_cycle(10'h001, rand_data(), 1'b1, 1'b0);
    drive_cycle('0, '0, 1'b1, 1'b0);
    checks++; if (stat_words !== 32'd15 || stat_words !== m_words) begin errors++; $display("FAIL stat_words: got %0d want 15", stat_words); end
    checks++; if (stat_stalls !== 32'd5 || stat_stalls !== m_stalls) begin errors++; $display("FAIL stat_stalls: got %0d want 5", stat_stalls); end
    drive_cycle('0, '0, 1'b0, 1'b1);
    checks++; if (stat_words !== 32'd0 || stat_stalls !== 32'd0) begin errors++; $display("FAIL stat_clear: words=%0d stalls=%0d want 0", stat_words, stat_stalls); end
  endtask
`endif

  initial begin
    test_reset();
    test_sparse();
    test_extremes();
    test_backpressure();
    test_streaming();
    test_softreset();
    test_random();
`ifdef LANE_COMPACT_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
